// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control, MULT/DIV busy sequencing and debug event counters
module hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rt,
    input  logic             id_rdhilo,
    input  logic             id_md,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    input  logic             ex_md_is_div,
    output logic             PCW,
    output logic             IFIDW,
    output logic             IDEXW,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT) + 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_next_state;
    logic [CW-1:0] r_cnt, w_next_cnt;
    logic r_busy, r_done, w_loaduse, w_mdhaz, w_bubble;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    // Hazard detection; a taken branch squashes the ID instruction so it beats any bubble
    always_comb begin
        w_loaduse  = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_use_rt && (ex_rt == id_rt)));
        w_mdhaz    = r_busy && (id_rdhilo || id_md);
        w_bubble   = !ex_branch_taken && (w_loaduse || w_mdhaz);
        PCW        = rst && !w_bubble;
        IFIDW      = rst && !w_bubble;
        IDEXW      = rst;
        flush_ifid = !rst || ex_branch_taken;
        flush_idex = !rst || ex_branch_taken || w_bubble;
    end

    // MULT/DIV occupancy: load latency on a legal issue, count down to the last busy cycle
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (r_state == IDLE) begin
            if (ex_md_start && !ex_branch_taken) begin
                w_next_state = BUSY;
                w_next_cnt   = ex_md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
            end
        end else begin
            w_next_cnt   = r_cnt - 1'b1;
            w_next_state = (r_cnt == CW'(1)) ? IDLE : BUSY;
        end
    end

    // State, busy/done flags and saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_busy  <= (w_next_state == BUSY);
            r_done  <= (w_next_state == BUSY) && (w_next_cnt == CW'(1));
            if (w_bubble && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (ex_branch_taken && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign md_busy   = r_busy;
    assign md_done   = r_done;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
endmodule
